// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register with an internal data memory.
// Define DM_ALIGN_CHECK_EN to add the M_adel misaligned-access flag.
module mem_wb_stage #(
    parameter int DM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_pc,
    input  logic [31:0] E_instr,
    input  logic        E_RFWR,
    input  logic [4:0]  E_A3,
    input  logic [2:0]  E_tnew,
    input  logic [31:0] E_ALUC,
    input  logic [31:0] E_RD2,
    output logic [31:0] M_pc,
    output logic [31:0] M_instr,
    output logic        M_RFWR,
    output logic [4:0]  M_A3,
    output logic [2:0]  M_tnew,
    output logic [31:0] M_data
`ifdef DM_ALIGN_CHECK_EN
    ,
    output logic        M_adel
`endif
);
    localparam int AW = $clog2(DM_WORDS);

    typedef enum logic [5:0] {
        OP_LB  = 6'b100000,
        OP_LH  = 6'b100001,
        OP_LW  = 6'b100011,
        OP_LBU = 6'b100100,
        OP_LHU = 6'b100101,
        OP_SB  = 6'b101000,
        OP_SH  = 6'b101001,
        OP_SW  = 6'b101011
    } mem_op_e;

    logic [31:0]   mem [DM_WORDS];
    logic [5:0]    opcode;
    logic [4:0]    rt;
    logic [AW-1:0] idx;
    logic          is_load;
    logic          is_store;
    logic          adel;
    logic          load_fault;
    logic [31:0]   sd;
    logic [31:0]   rword;
    logic [31:0]   wword;
    logic [31:0]   load_data;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;

    assign opcode = E_instr[31:26];
    assign rt     = E_instr[20:16];
    assign idx    = E_ALUC[AW+1:2];
    assign rword  = mem[idx];

    // Store data comes from our own registered result when the previous instruction writes rt.
    assign sd = (M_RFWR && (M_A3 == rt) && (M_A3 != 5'd0)) ? M_data : E_RD2;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (opcode)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load  = 1'b1;
            OP_SB, OP_SH, OP_SW:                 is_store = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        adel = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
        case (opcode)
            OP_LW, OP_SW:         adel = |E_ALUC[1:0];
            OP_LH, OP_LHU, OP_SH: adel = E_ALUC[0];
            default: ;
        endcase
`endif
    end

    assign load_fault = is_load & adel;

    always_comb begin
        rbyte = rword[7:0];
        case (E_ALUC[1:0])
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            2'd3:    rbyte = rword[31:24];
            default: ;
        endcase
        rhalf     = E_ALUC[1] ? rword[31:16] : rword[15:0];
        load_data = rword;
        case (opcode)
            OP_LB:   load_data = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  load_data = {24'd0, rbyte};
            OP_LH:   load_data = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  load_data = {16'd0, rhalf};
            default: ;
        endcase
    end

    // Partial stores merge into the current word so untouched lanes keep their value.
    always_comb begin
        wword = rword;
        case (opcode)
            OP_SW: wword = sd;
            OP_SH: begin
                if (E_ALUC[1]) wword[31:16] = sd[15:0];
                else           wword[15:0]  = sd[15:0];
            end
            OP_SB: begin
                case (E_ALUC[1:0])
                    2'd0: wword[7:0]   = sd[7:0];
                    2'd1: wword[15:8]  = sd[7:0];
                    2'd2: wword[23:16] = sd[7:0];
                    2'd3: wword[31:24] = sd[7:0];
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                mem[i[AW-1:0]] <= '0;
            end
        end else if (is_store && !adel) begin
            mem[idx] <= wword;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            M_pc    <= '0;
            M_instr <= '0;
            M_RFWR  <= 1'b0;
            M_A3    <= '0;
            M_tnew  <= '0;
            M_data  <= '0;
`ifdef DM_ALIGN_CHECK_EN
            M_adel  <= 1'b0;
`endif
        end else begin
            M_pc    <= E_pc;
            M_instr <= E_instr;
            M_RFWR  <= E_RFWR & ~load_fault;
            M_A3    <= E_A3;
            M_tnew  <= (E_tnew == 3'd0) ? 3'd0 : E_tnew - 3'd1;
            if (load_fault)   M_data <= '0;
            else if (is_load) M_data <= load_data;
            else              M_data <= E_ALUC;
`ifdef DM_ALIGN_CHECK_EN
            M_adel  <= adel;
`endif
        end
    end
endmodule
